// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding and constants for the sqrt / square datapath blocks
//   Shared by the fixed-point sqrt block and fixed_square_iter.
//   sq_state_e  : three-state sequencer encoding (IDLE, CALC, DONE)
//   SQRT_DSIZE  : default fraction width for the sqrt / square blocks (Q0.16)
//   SQRT_ITER   : sqrt iterations, one result bit per step
//   SQRT_CW     : width of an iteration counter that must reach SQRT_ITER
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_e;

    localparam int SQRT_DSIZE = 16;
    localparam int SQRT_ITER  = SQRT_DSIZE;
    localparam int SQRT_CW    = $clog2(SQRT_ITER + 1);

endpackage

// File: rtl/fixed_square_iter.sv
// fixed_square_iter: iterative shift-add square of an unsigned Q0.DSIZE fraction
//   clock     : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand d valid (accepted while in_ready)
//   in_ready  : high in IDLE only
//   d         : operand, Q0.DSIZE
//   out_valid : high in DONE only, q is the result
//   out_ready : consumer takes q; DONE -> IDLE
//   q         : floor(d*d / 2**DSIZE), held until the next result
module fixed_square_iter
    import sqrt_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] q
);

    localparam int CW = $clog2(DSIZE + 1);

    sq_state_e          state, state_nx;
    logic [CW-1:0]      cnt;
    logic [DSIZE-1:0]   op_r;
    logic [DSIZE-1:0]   mul_r;
    logic [2*DSIZE-1:0] acc, acc_nx;
    logic [DSIZE:0]     sum;
    logic               last;

    // Classic LSB-first multiplier: add the multiplicand into the upper half,
    // then shift the whole accumulator (plus carry) right by one.
    always_comb begin
        sum    = {1'b0, acc[2*DSIZE-1:DSIZE]} + (mul_r[0] ? {1'b0, op_r} : '0);
        acc_nx = (2*DSIZE)'({sum, acc[DSIZE-1:0]} >> 1);
        last   = cnt == CW'(DSIZE - 1);
    end

    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        unique case (state)
            IDLE:    state_nx = in_valid  ? CALC : IDLE;
            CALC:    state_nx = last      ? DONE : CALC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= '0;
            mul_r <= '0;
            acc   <= '0;
            q     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                op_r  <= d;
                mul_r <= d;
                acc   <= '0;
                cnt   <= '0;
            end
            if (state == CALC) begin
                acc   <= acc_nx;
                mul_r <= mul_r >> 1;
                cnt   <= cnt + CW'(1);
                // q moves only on the final step so it keeps the last result otherwise
                if (last)
                    q <= acc_nx[2*DSIZE-1:DSIZE];
            end
        end
    end

endmodule

// File: tb/tb_fixed_square_iter.sv
// tb_fixed_square_iter: directed scoreboard bench for fixed_square_iter
module tb_fixed_square_iter;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] d = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] q;

    int checks = 0;
    int fails  = 0;
    logic [15:0] sb[$];

    fixed_square_iter #(.DSIZE(16)) dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1);
    end

    function automatic logic [15:0] sq(input logic [15:0] v);
        logic [31:0] p;
        p = 32'(v) * 32'(v);
        return p[31:16];
    endfunction

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [15:0] r, t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (32'(t) * 32'(t) <= v) r = t;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        d = v;
        tick();
        in_valid = 1'b0;
        sb.push_back(sq(v));
    endtask

    // d is scrambled every CALC cycle: the result must depend only on the captured operand
    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            tick();
            n++;
            d = 16'($urandom);
            if (n == 1) chk("in_ready_calc", in_ready, 0);
        end while (!out_valid && n < 40);
        chk("latency", n, 16);
    endtask

    task automatic check_result(input string tag, output logic [15:0] got);
        chk("scoreboard_nonempty", sb.size() > 0, 1);
        got = q;
        if (sb.size() > 0) chk(tag, q, sb.pop_front());
    endtask

    task automatic op(input string tag, input logic [15:0] v);
        logic [15:0] got;
        send(v);
        wait_valid();
        check_result(tag, got);
        tick();
        chk("out_valid_after_take", out_valid, 0);
        chk("in_ready_after_take", in_ready, 1);
    endtask

    initial begin
        logic [15:0] qv, got;
        int seen, code;
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_q", q, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_q", q, 0);

        op("q_e666", 16'hE666);
        chk("q_e666_const", q, 16'hCF5B);
        op("q_ffff", 16'hFFFF);
        chk("q_ffff_const", q, 16'hFFFE);
        op("q_8000", 16'h8000);
        chk("q_8000_const", q, 16'h4000);
        op("q_0001", 16'h0001);
        op("q_0000", 16'h0000);
        op("q_1234", 16'h1234);

        // backpressure with a competing operand presented the whole time
        out_ready = 1'b0;
        send(16'h5A5A);
        wait_valid();
        qv = q;
        in_valid = 1'b1;
        d = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_q_stable", q, qv);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        check_result("bp_q", got);
        out_ready = 1'b1;
        tick();
        chk("bp_released_out_valid", out_valid, 0);
        chk("bp_no_accept_in_done", in_ready, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_still_idle", in_ready, 1);

        // reset in the middle of CALC aborts the operation
        send(16'hE666);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        rst_n = 1'b0;
        in_valid = 1'b1;
        d = 16'h1111;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_q", q, 0);
        tick();
        tick();
        chk("reset_no_handshake", in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        void'(sb.pop_back());
        repeat (20) begin
            tick();
            if (out_valid) seen++;
        end
        chk("aborted_no_result", seen, 0);
        op("post_reset_8000", 16'h8000);
        chk("post_reset_8000_const", q, 16'h4000);

        // round trip through the integer square root of 0.9 .. 0.1
        for (int k = 9; k >= 1; k--) begin
            code = (k * 65536 + 5) / 10;
            send(isqrt(32'(code) << 16));
            wait_valid();
            check_result("rt_q", got);
            chk("rt_within_2lsb", (code - int'(got)) <= 2 && (code - int'(got)) >= 0, 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fixed_square_iter.md
FIXED_SQUARE_ITER -- requirements
Module: fixed_square_iter

Interface
REQ-001 SHALL have parameter DSIZE, default 16, giving the operand and result width in bits (unsigned fraction Q0.DSIZE, value = code/2**DSIZE).
REQ-002 SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand d is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-006 SHALL have port d, input, DSIZE bits: operand to square.
REQ-007 SHALL have port out_valid, output, 1 bit: result q is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts q.
REQ-009 SHALL have port q, output, DSIZE bits: truncated square, q = floor(d*d / 2**DSIZE).

Function
REQ-010 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-011 SHALL drive in_ready = 1 only in IDLE and drive out_valid = 1 only in DONE; both SHALL be decoded from registered state.
REQ-012 SHALL accept an operand on a rising edge where in_valid && in_ready, capture d, clear the 2*DSIZE-bit accumulator and the iteration counter, and move IDLE -> CALC.
REQ-013 SHALL, in CALC, perform one shift-add step per cycle, LSB-first over the multiplier bits of the captured d, for exactly DSIZE cycles.
REQ-014 SHALL use an iteration counter of width $clog2(DSIZE+1) and move CALC -> DONE on the edge that completes step DSIZE.
REQ-015 SHALL assert out_valid exactly DSIZE rising edges after the accepting edge (latency DSIZE cycles).
REQ-016 SHALL hold q and out_valid stable in DONE until out_ready = 1, then move DONE -> IDLE on that edge.
REQ-017 SHALL have throughput of at most one result per DSIZE+2 cycles; no operand is accepted in CALC or DONE, including in the DONE cycle where out_ready = 1.
REQ-018 SHALL ignore in_valid and d outside IDLE; a changing d during CALC SHALL NOT affect the result.
REQ-019 SHALL take q from accumulator bits [2*DSIZE-1:DSIZE] with truncation; no rounding and no saturation (the result cannot overflow).
REQ-020 SHALL hold the previous result on q in IDLE and CALC; q is only meaningful while out_valid = 1.
REQ-021 SHALL NOT treat d = 0 or d = all-ones specially: both take the full DSIZE cycles.
REQ-022 SHALL ensure out_ready without out_valid has no effect.

Reset
REQ-023 SHALL, while rst_n = 0, asynchronously force state = IDLE, counter = 0, accumulator = 0, captured operand = 0, q = 0 and out_valid = 0.
REQ-024 SHALL hold in_ready = 1 (state IDLE), but no handshake is honoured while rst_n = 0.
REQ-025 SHALL, on reset mid-CALC or mid-DONE, abort the operation with no result output; the first post-reset operand is processed normally.

Structure
REQ-026 SHALL place the FSM state enum typedef (IDLE, CALC, DONE) in the shared package sqrt_pkg, alongside the sqrt block's constants.
REQ-027 SHALL be a single module with no sub-module; the shift-add datapath is inline.
REQ-028 SHALL register all outputs or decode them from registered state only, with no combinational path from input to output.

Verification
REQ-029 Reset release, idle: in_ready = 1, out_valid = 0, q = 0.
REQ-030 d = 0xE666 (0.9), out_ready held 1: out_valid rises 16 cycles after accept with q = 0xCF5B; in_ready returns 1 one cycle later.
REQ-031 d = 0xFFFF -> q = 0xFFFE; d = 0x8000 -> q = 0x4000; d = 0x0001 -> q = 0x0000; d = 0x0000 -> q = 0x0000.
REQ-032 Backpressure: out_ready = 0 for 5 cycles after out_valid: q and out_valid stable, in_ready = 0, and a new in_valid with d = 0x1234 is not accepted.
REQ-033 Reset pulse 8 cycles after accepting d = 0xE666: out_valid never asserts; then d = 0x8000 yields q = 0x4000 after 16 cycles.
REQ-034 Round trip: feed the sqrt block output for d = 0.9 down to 0.1 (step 0.1) into this block: each q is within 2 LSB of the original d.
